// File: rtl/cpu_trace_pkg.sv
// Shared encodings for the trace run-control block: host ops, control states
// and bit positions inside the packed status word.
package cpu_trace_pkg;

    localparam logic [1:0] OP_STEP  = 2'd0;
    localparam logic [1:0] OP_RUN   = 2'd1;
    localparam logic [1:0] OP_STOP  = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        ST_HALT      = 2'd0,
        ST_RUN       = 2'd1,
        ST_STEP      = 2'd2,
        ST_FULL_WAIT = 2'd3
    } trace_state_e;

    localparam int SO_STATE_LO = 0;
    localparam int SO_OVERFLOW = 2;
    localparam int SO_STALL    = 3;
    localparam int SO_VALID    = 4;
    localparam int SO_COUNT_LO = 8;

endpackage

// File: rtl/cpu_trace_fifo.sv
// Synchronous trace FIFO with flush; a push while full succeeds only when a
// pop happens in the same cycle.
module cpu_trace_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;
    // Head reads as zero while empty so the output never shows stale words.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/cpu_trace_ctrl.sv
// Host run-control (run / stop / N-step) and trace capture for cpu_top, with
// stall back-pressure when the trace FIFO nears full.
module cpu_trace_ctrl
    import cpu_trace_pkg::*;
#(
    parameter int TRACE_W       = 128,
    parameter int DEPTH         = 16,
    parameter int STEP_W        = 32,
    parameter int SKID          = 2,
    parameter int STALL_ON_FULL = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               host_cmd_valid,
    output logic               host_cmd_ready,
    input  logic [1:0]         host_cmd_op,
    input  logic [STEP_W-1:0]  host_cmd_arg,
    input  logic [TRACE_W-1:0] trace_in,
    input  logic               trace_valid_in,
    output logic               stall_out,
    output logic               resume_out,
    output logic [TRACE_W-1:0] trace_out,
    output logic               trace_out_valid,
    input  logic               trace_out_ready,
    output logic [31:0]        state_out
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_MARK = CW'(DEPTH - SKID);
    localparam logic [CW-1:0] HALF_MARK = CW'(DEPTH / 2);

    trace_state_e      state_q, state_d;
    trace_state_e      saved_q, saved_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              stall_q, stall_d;
    logic              resume_q;
    logic              overflow_q;
    logic              ready_q;

    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     cnt_after;
    logic              cmd_ok, is_run, is_stop, is_step, do_clear;
    logic              pop_ok, push_ok, drop, near_full;
    logic [31:0]       cnt_wide;

    // Commands are accepted whenever valid is high once reset has been left;
    // ready is a registered constant 1 outside reset.
    assign cmd_ok   = host_cmd_valid & ready_q;
    assign is_run   = cmd_ok & (host_cmd_op == OP_RUN);
    assign is_stop  = cmd_ok & (host_cmd_op == OP_STOP);
    assign is_step  = cmd_ok & (host_cmd_op == OP_STEP);
    assign do_clear = cmd_ok & (host_cmd_op == OP_CLEAR);

    assign pop_ok    = trace_out_ready & ~fifo_empty & ~do_clear;
    assign push_ok   = trace_valid_in & (~fifo_full | pop_ok) & ~do_clear;
    assign drop      = trace_valid_in & fifo_full & ~pop_ok & ~do_clear;
    assign near_full = (STALL_ON_FULL != 0) && (cnt_after >= FULL_MARK);

    cpu_trace_fifo #(
        .WIDTH (TRACE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (do_clear),
        .push  (trace_valid_in),
        .pop   (trace_out_ready),
        .wdata (trace_in),
        .rdata (trace_out),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        cnt_after = fifo_count;
        if (do_clear)               cnt_after = '0;
        else if (push_ok && !pop_ok) cnt_after = fifo_count + 1'b1;
        else if (!push_ok && pop_ok) cnt_after = fifo_count - 1'b1;
    end

    // Entering a running mode with the FIFO already near full goes straight
    // to FULL_WAIT so the CPU never sees a one-cycle release.
    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        step_d  = step_q;
        case (state_q)
            ST_HALT: begin
                if (is_run) begin
                    saved_d = ST_RUN;
                    state_d = near_full ? ST_FULL_WAIT : ST_RUN;
                end else if (is_step && host_cmd_arg != '0) begin
                    step_d  = host_cmd_arg;
                    saved_d = ST_STEP;
                    state_d = near_full ? ST_FULL_WAIT : ST_STEP;
                end
            end
            ST_RUN: begin
                if (is_stop) begin
                    state_d = ST_HALT;
                end else if (near_full) begin
                    saved_d = ST_RUN;
                    state_d = ST_FULL_WAIT;
                end
            end
            ST_STEP: begin
                if (is_stop) begin
                    step_d  = '0;
                    state_d = ST_HALT;
                end else if (is_run) begin
                    saved_d = ST_RUN;
                    state_d = near_full ? ST_FULL_WAIT : ST_RUN;
                end else begin
                    if (trace_valid_in && step_q != '0) step_d = step_q - 1'b1;
                    if (trace_valid_in && step_q == STEP_W'(1)) begin
                        state_d = ST_HALT;
                    end else if (near_full) begin
                        saved_d = ST_STEP;
                        state_d = ST_FULL_WAIT;
                    end
                end
            end
            ST_FULL_WAIT: begin
                if (is_stop) begin
                    step_d  = '0;
                    state_d = ST_HALT;
                end else if (cnt_after <= HALF_MARK) begin
                    state_d = saved_q;
                end
            end
            default: state_d = ST_HALT;
        endcase
        stall_d = (state_d == ST_HALT) || (state_d == ST_FULL_WAIT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_HALT;
            saved_q    <= ST_RUN;
            step_q     <= '0;
            stall_q    <= 1'b1;
            resume_q   <= 1'b0;
            overflow_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            saved_q  <= saved_d;
            step_q   <= step_d;
            stall_q  <= stall_d;
            resume_q <= stall_q & ~stall_d;
            ready_q  <= 1'b1;
            if (do_clear)  overflow_q <= 1'b0;
            else if (drop) overflow_q <= 1'b1;
        end
    end

    assign host_cmd_ready  = ready_q;
    assign stall_out       = stall_q;
    assign resume_out      = resume_q;
    assign trace_out_valid = ~fifo_empty;

    always_comb begin
        cnt_wide  = 32'(fifo_count);
        state_out = '0;
        state_out[SO_STATE_LO +: 2] = state_q;
        state_out[SO_OVERFLOW]      = overflow_q;
        state_out[SO_STALL]         = stall_q;
        state_out[SO_VALID]         = ~fifo_empty;
        state_out[SO_COUNT_LO +: 8] = (cnt_wide > 32'd255) ? 8'hFF : cnt_wide[7:0];
    end

endmodule

// File: tb/tb_cpu_trace_ctrl.sv
// Directed bench for cpu_trace_ctrl: instance a back-pressures on full,
// instance b drops on full. Popped trace words are checked against queues.
module tb_cpu_trace_ctrl;
    import cpu_trace_pkg::*;

    localparam int TRACE_W = 128;
    localparam int DEPTH   = 16;
    localparam int STEP_W  = 32;
    localparam int SKID    = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    logic               cmd_valid_a, cmd_ready_a, trace_valid_a, out_valid_a, out_ready_a, stall_a, resume_a;
    logic [1:0]         cmd_op_a;
    logic [STEP_W-1:0]  cmd_arg_a;
    logic [TRACE_W-1:0] trace_in_a, trace_out_a;
    logic [31:0]        state_a;

    logic               cmd_valid_b, cmd_ready_b, trace_valid_b, out_valid_b, out_ready_b, stall_b, resume_b;
    logic [1:0]         cmd_op_b;
    logic [STEP_W-1:0]  cmd_arg_b;
    logic [TRACE_W-1:0] trace_in_b, trace_out_b;
    logic [31:0]        state_b;

    int checks   = 0;
    int failures = 0;
    logic [TRACE_W-1:0] exp_q_a[$];
    logic [TRACE_W-1:0] exp_q_b[$];
    logic [TRACE_W-1:0] head_a, head_b;

    cpu_trace_ctrl #(.TRACE_W(TRACE_W), .DEPTH(DEPTH), .STEP_W(STEP_W), .SKID(SKID), .STALL_ON_FULL(1)) dut_a (
        .clock(clock), .reset(reset),
        .host_cmd_valid(cmd_valid_a), .host_cmd_ready(cmd_ready_a),
        .host_cmd_op(cmd_op_a), .host_cmd_arg(cmd_arg_a),
        .trace_in(trace_in_a), .trace_valid_in(trace_valid_a),
        .stall_out(stall_a), .resume_out(resume_a),
        .trace_out(trace_out_a), .trace_out_valid(out_valid_a), .trace_out_ready(out_ready_a),
        .state_out(state_a)
    );

    cpu_trace_ctrl #(.TRACE_W(TRACE_W), .DEPTH(DEPTH), .STEP_W(STEP_W), .SKID(SKID), .STALL_ON_FULL(0)) dut_b (
        .clock(clock), .reset(reset),
        .host_cmd_valid(cmd_valid_b), .host_cmd_ready(cmd_ready_b),
        .host_cmd_op(cmd_op_b), .host_cmd_arg(cmd_arg_b),
        .trace_in(trace_in_b), .trace_valid_in(trace_valid_b),
        .stall_out(stall_b), .resume_out(resume_b),
        .trace_out(trace_out_b), .trace_out_valid(out_valid_b), .trace_out_ready(out_ready_b),
        .state_out(state_b)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cmd_a(input logic [1:0] op, input logic [STEP_W-1:0] arg);
        cmd_valid_a = 1'b1; cmd_op_a = op; cmd_arg_a = arg;
        tick();
        cmd_valid_a = 1'b0;
    endtask

    task automatic cmd_b(input logic [1:0] op, input logic [STEP_W-1:0] arg);
        cmd_valid_b = 1'b1; cmd_op_b = op; cmd_arg_b = arg;
        tick();
        cmd_valid_b = 1'b0;
    endtask

    task automatic retire_a(input logic [TRACE_W-1:0] word, input bit expect_pop);
        trace_valid_a = 1'b1; trace_in_a = word;
        if (expect_pop) exp_q_a.push_back(word);
        tick();
        trace_valid_a = 1'b0;
    endtask

    task automatic retire_b(input logic [TRACE_W-1:0] word, input bit expect_pop);
        trace_valid_b = 1'b1; trace_in_b = word;
        if (expect_pop) exp_q_b.push_back(word);
        tick();
        trace_valid_b = 1'b0;
    endtask

    task automatic pop_a(input int n);
        out_ready_a = 1'b1;
        repeat (n) tick();
        out_ready_a = 1'b0;
    endtask

    task automatic pop_b(input int n);
        out_ready_b = 1'b1;
        repeat (n) tick();
        out_ready_b = 1'b0;
    endtask

    // Monitors: every accepted pop is compared with the oldest expected word.
    always @(negedge clock) begin
        if (!reset && out_valid_a && out_ready_a) begin
            checks++;
            if (exp_q_a.size() == 0) begin
                failures++;
                $display("FAIL pop_a_unexpected: got 0x%0h expected no word", trace_out_a);
            end else begin
                head_a = exp_q_a.pop_front();
                if (trace_out_a !== head_a) begin
                    failures++;
                    $display("FAIL pop_a_word: got 0x%0h expected 0x%0h", trace_out_a, head_a);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && out_valid_b && out_ready_b) begin
            checks++;
            if (exp_q_b.size() == 0) begin
                failures++;
                $display("FAIL pop_b_unexpected: got 0x%0h expected no word", trace_out_b);
            end else begin
                head_b = exp_q_b.pop_front();
                if (trace_out_b !== head_b) begin
                    failures++;
                    $display("FAIL pop_b_word: got 0x%0h expected 0x%0h", trace_out_b, head_b);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        cmd_valid_a = 0; cmd_op_a = 0; cmd_arg_a = 0; trace_valid_a = 0; trace_in_a = 0; out_ready_a = 0;
        cmd_valid_b = 0; cmd_op_b = 0; cmd_arg_b = 0; trace_valid_b = 0; trace_in_b = 0; out_ready_b = 0;

        // Reset held for three cycles
        repeat (3) tick();
        check("ready_in_reset", 32'(cmd_ready_a), 32'd0);
        reset = 1'b0;
        tick();
        check("rst_stall", 32'(stall_a), 32'd1);
        check("rst_resume", 32'(resume_a), 32'd0);
        check("rst_valid", 32'(out_valid_a), 32'd0);
        check("rst_trace_out", trace_out_a[31:0], 32'd0);
        check("rst_state_out", state_a, 32'h0000_0008);
        check("rst_ready", 32'(cmd_ready_a), 32'd1);
        check("rst_state_out_b", state_b, 32'h0000_0008);

        // STEP 3 followed by five consecutive retires
        cmd_a(OP_STEP, 32'd3);
        check("step_resume", 32'(resume_a), 32'd1);
        check("step_stall", 32'(stall_a), 32'd0);
        check("step_state", state_a, 32'h0000_0002);
        for (int i = 0; i < 5; i++) begin
            trace_valid_a = 1'b1;
            trace_in_a = TRACE_W'(32'hA + i);
            exp_q_a.push_back(trace_in_a);
            tick();
            check("step_no_resume", 32'(resume_a), 32'd0);
            check("step_stall_seq", 32'(stall_a), (i < 2) ? 32'd0 : 32'd1);
        end
        trace_valid_a = 1'b0;
        check("step_done_state", state_a, 32'h0000_0518);
        pop_a(5);
        check("step_drained", 32'(out_valid_a), 32'd0);

        // HALT no-ops: STEP 0 and STOP
        cmd_a(OP_STEP, 32'd0);
        check("step0_noop", state_a, 32'h0000_0008);
        cmd_a(OP_STOP, 32'd0);
        check("stop_noop", state_a, 32'h0000_0008);

        // RUN with a retire every cycle until the skid threshold
        cmd_a(OP_RUN, 32'd0);
        check("run_resume", 32'(resume_a), 32'd1);
        check("run_state", state_a, 32'h0000_0001);
        for (int i = 0; i < 13; i++) retire_a(TRACE_W'(32'h100 + i), 1'b1);
        check("run_13_state", state_a, 32'h0000_0D11);
        retire_a(TRACE_W'(32'h10D), 1'b1);
        check("full_wait_state", state_a, 32'h0000_0E1B);
        check("full_wait_stall", 32'(stall_a), 32'd1);
        pop_a(5);
        check("full_wait_cnt9", state_a, 32'h0000_091B);
        pop_a(1);
        check("full_wait_exit", state_a, 32'h0000_0811);
        check("full_wait_resume", 32'(resume_a), 32'd1);
        tick();
        check("full_wait_resume_end", 32'(resume_a), 32'd0);
        pop_a(8);
        cmd_a(OP_STOP, 32'd0);
        check("run_stop", state_a, 32'h0000_0008);

        // CLEAR in the same cycle as a retire with four words held
        for (int i = 0; i < 4; i++) retire_a(TRACE_W'(32'h200 + i), 1'b0);
        check("clear_pre", state_a, 32'h0000_0418);
        cmd_valid_a = 1'b1; cmd_op_a = OP_CLEAR; trace_valid_a = 1'b1; trace_in_a = TRACE_W'(32'hDEAD);
        tick();
        cmd_valid_a = 1'b0; trace_valid_a = 1'b0;
        check("clear_state", state_a, 32'h0000_0008);
        retire_a(TRACE_W'(32'h55), 1'b1);
        pop_a(1);

        // STEP 10, four retires, then a one-cycle reset
        cmd_a(OP_STEP, 32'd10);
        for (int i = 0; i < 4; i++) retire_a(TRACE_W'(32'h300 + i), 1'b0);
        check("midstep_state", state_a, 32'h0000_0412);
        reset = 1'b1;
        tick();
        check("midreset_ready", 32'(cmd_ready_a), 32'd0);
        check("midreset_state", state_a, 32'h0000_0008);
        reset = 1'b0;
        tick();
        check("postreset_ready", 32'(cmd_ready_a), 32'd1);
        check("postreset_state", state_a, 32'h0000_0008);
        cmd_a(OP_RUN, 32'd0);
        check("postreset_run", state_a, 32'h0000_0001);
        check("postreset_resume", 32'(resume_a), 32'd1);
        retire_a(TRACE_W'(32'h77), 1'b1);
        pop_a(1);
        check("postreset_run_hold", state_a, 32'h0000_0001);

        // Drop-on-full instance: 20 retires, no pops
        cmd_b(OP_RUN, 32'd0);
        for (int i = 0; i < 20; i++) retire_b(TRACE_W'(32'h400 + i), i < 16);
        check("drop_state", state_b, 32'h0000_1015);
        check("drop_stall", 32'(stall_b), 32'd0);
        pop_b(16);
        check("drop_drained", state_b, 32'h0000_0005);
        for (int i = 0; i < 3; i++) retire_b(TRACE_W'(32'h500 + i), 1'b0);
        check("drop_sticky", state_b, 32'h0000_0315);
        cmd_b(OP_CLEAR, 32'd0);
        check("drop_clear", state_b, 32'h0000_0001);

        tick();
        check("queue_a_empty", 32'(exp_q_a.size()), 32'd0);
        check("queue_b_empty", 32'(exp_q_b.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
